// File: rtl/bnn_pkg.sv
// Shared constants and state encoding for the binarized XNOR neuron stage.
// Defaults size the stage for a 32-bit activation vector delivered as four bytes.
package bnn_pkg;

  localparam int CHUNK_W    = 8;
  localparam int NUM_CHUNKS = 4;
  localparam int CNT_W      = $clog2(CHUNK_W * NUM_CHUNKS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Width needed to hold a popcount of w bits.
  function automatic int pop_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/bnn_xnor_neuron_if.sv
// Configuration, activation-stream and result-stream signals of the neuron stage.
// The producer/consumer side uses master; the neuron itself uses slave.
interface bnn_xnor_neuron_if import bnn_pkg::*; #(
  parameter int CHUNK_W = bnn_pkg::CHUNK_W,
  parameter int CNT_W   = bnn_pkg::CNT_W
);

  logic               wt_load;
  logic [CHUNK_W-1:0] wt_data;
  logic               thr_load;
  logic [CNT_W-1:0]   thr_data;
  logic               in_valid;
  logic               in_ready;
  logic [CHUNK_W-1:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic               out_bit;
  logic [CNT_W-1:0]   out_pop;

  modport master (
    output wt_load, wt_data, thr_load, thr_data, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_bit, out_pop
  );

  modport slave (
    input  wt_load, wt_data, thr_load, thr_data, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_bit, out_pop
  );

endinterface

// File: rtl/bnn_popcount.sv
// Combinational population count of a W-bit word.
module bnn_popcount import bnn_pkg::*; #(
  parameter int W     = bnn_pkg::CHUNK_W,
  parameter int OUT_W = $clog2(W + 1)
) (
  input  logic [W-1:0]     bits,
  output logic [OUT_W-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) begin
      count = count + OUT_W'(bits[i]);
    end
  end

endmodule

// File: rtl/bnn_xnor_neuron.sv
// Binarized neuron: XNOR each activation chunk with its stored weight chunk,
// accumulate the popcount over a vector and emit popcount plus sign bit.
module bnn_xnor_neuron import bnn_pkg::*; #(
  parameter int CHUNK_W    = bnn_pkg::CHUNK_W,
  parameter int NUM_CHUNKS = bnn_pkg::NUM_CHUNKS,
  parameter int CNT_W      = bnn_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  bnn_xnor_neuron_if.slave   bus
);

  localparam int IDX_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int PW    = pop_w(CHUNK_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  state_t             state_reg;
  logic [IDX_W-1:0]   chunk_idx_reg;
  logic [IDX_W-1:0]   wt_ptr_reg;
  logic [CNT_W-1:0]   acc_reg;
  logic [CNT_W-1:0]   thr_reg;
  logic [CNT_W-1:0]   out_pop_reg;
  logic               out_valid_reg;
  logic               out_bit_reg;

  logic [CHUNK_W-1:0] weight_arr [NUM_CHUNKS];
  logic [CHUNK_W-1:0] sel_weight;
  logic [CHUNK_W-1:0] xnor_bits;
  logic [PW-1:0]      chunk_pop;
  logic [CNT_W-1:0]   acc_base;
  logic [CNT_W-1:0]   sum_next;
  logic               in_ready_int;
  logic               accept;
  logic               cfg_idle;
  logic               wt_we;

  // Ready drops with reset so nothing is accepted while rst_n is low.
  assign in_ready_int = rst_n & (state_reg != DONE);
  assign accept       = bus.in_valid & in_ready_int;
  assign cfg_idle     = (state_reg == IDLE);
  assign wt_we        = bus.wt_load & cfg_idle;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHUNKS; gi++) begin : g_wslot
      logic [CHUNK_W-1:0] slot_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          slot_reg <= '0;
        end else if (wt_we && (wt_ptr_reg == IDX_W'(gi))) begin
          slot_reg <= bus.wt_data;
        end
      end

      assign weight_arr[gi] = slot_reg;
    end
  endgenerate

  assign sel_weight = weight_arr[chunk_idx_reg];
  assign xnor_bits  = ~(bus.in_data ^ sel_weight);

  bnn_popcount #(
    .W     (CHUNK_W),
    .OUT_W (PW)
  ) u_popcount (
    .bits  (xnor_bits),
    .count (chunk_pop)
  );

  // A new frame always starts from zero, whatever acc_reg still holds.
  assign acc_base = cfg_idle ? '0 : acc_reg;
  assign sum_next = acc_base + CNT_W'(chunk_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      chunk_idx_reg <= '0;
      wt_ptr_reg    <= '0;
      acc_reg       <= '0;
      thr_reg       <= '0;
      out_pop_reg   <= '0;
      out_valid_reg <= 1'b0;
      out_bit_reg   <= 1'b0;
    end else begin
      if (cfg_idle && bus.thr_load) begin
        thr_reg <= bus.thr_data;
      end
      if (wt_we) begin
        wt_ptr_reg <= (wt_ptr_reg == LAST_IDX) ? '0 : wt_ptr_reg + IDX_W'(1);
      end

      case (state_reg)
        IDLE, ACCUM: begin
          if (accept) begin
            acc_reg <= sum_next;
            if (chunk_idx_reg == LAST_IDX) begin
              state_reg     <= DONE;
              chunk_idx_reg <= '0;
              out_valid_reg <= 1'b1;
              out_pop_reg   <= sum_next;
              out_bit_reg   <= (sum_next >= thr_reg);
            end else begin
              state_reg     <= ACCUM;
              chunk_idx_reg <= chunk_idx_reg + IDX_W'(1);
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            acc_reg       <= '0;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_pop   = out_pop_reg;
  assign bus.out_bit   = out_bit_reg;

endmodule
